// File: rtl/score_display_ctrl.sv
// Digit sequencer for the 4-digit 7-segment driver: mux strobe, sequential BCD conversion, score/message arbitration.
// Optional message blinking is built when SCORE_DISP_FLASH_EN is defined.
module score_display_ctrl #(
  parameter int MUX_DIV    = 100000,
  parameter int HOLD_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score,
  input  logic        score_valid,
  input  logic        msg_req,
  input  logic [15:0] msg_code,
  output logic        msg_ack,
  output logic        busy,
  output logic        mux_clk,
  output logic [3:0]  val1,
  output logic [3:0]  val2,
  output logic [3:0]  val3,
  output logic [3:0]  val4
);

  localparam int CNT_W  = (MUX_DIV > 2) ? $clog2(MUX_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  function automatic logic [13:0] sat_score(input logic [13:0] s);
    return (s > 14'd9999) ? 14'd9999 : s;
  endfunction

  // one double-dabble iteration on {bcd[15:0], bin[13:0]}
  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd5) t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  function automatic logic [15:0] blank_lz(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    if (b[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (b[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (b[7:4] == 4'd0) r[7:4] = 4'hF;
      end
    end
    return r;
  endfunction

  logic [CNT_W-1:0] cnt_p0, cnt_nx;

  always_comb begin
    cnt_nx = (cnt_p0 == CNT_W'(MUX_DIV - 1)) ? '0 : cnt_p0 + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0  <= '0;
      mux_clk <= 1'b0;
    end else begin
      cnt_p0  <= cnt_nx;
      mux_clk <= (cnt_nx == CNT_W'(MUX_DIV - 1));
    end
  end

  state_t        state_p0, state_nx;
  logic [3:0]    iter_p0;
  logic [29:0]   shreg_p0;
  logic [15:0]   score_bcd_p1;
  logic          pend_vld_p0;
  logic [13:0]   pend_score_p0;
  logic          start, shift_en, load_en;
  logic [13:0]   start_val;

  always_comb begin
    state_nx  = state_p0;
    start     = 1'b0;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    start_val = sat_score(score_valid ? score : pend_score_p0);
    case (state_p0)
      IDLE: if (score_valid || pend_vld_p0) begin
        start    = 1'b1;
        state_nx = CONV;
      end
      CONV: begin
        shift_en = 1'b1;
        if (iter_p0 == 4'd13) state_nx = LOAD;
      end
      LOAD: begin
        load_en  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0     <= IDLE;
      iter_p0      <= 4'd0;
      busy         <= 1'b0;
      pend_vld_p0  <= 1'b0;
      score_bcd_p1 <= 16'd0;
    end else begin
      state_p0 <= state_nx;
      busy     <= (state_nx != IDLE);
      if (start) iter_p0 <= 4'd0;
      else if (shift_en) iter_p0 <= iter_p0 + 4'd1;
      if (load_en) score_bcd_p1 <= shreg_p0[29:14];
      // a request arriving mid-conversion overwrites any earlier one
      if (state_p0 != IDLE && score_valid) pend_vld_p0 <= 1'b1;
      else if (start) pend_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) shreg_p0 <= {16'd0, start_val};
    else if (shift_en) shreg_p0 <= dd_step(shreg_p0);
    if (state_p0 != IDLE && score_valid) pend_score_p0 <= score;
  end

  logic              active_p0;
  logic [HOLD_W-1:0] hold_p0;
  logic [15:0]       msg_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_ack   <= 1'b0;
      active_p0 <= 1'b0;
      hold_p0   <= '0;
    end else begin
      msg_ack <= msg_req;
      if (msg_req) begin
        active_p0 <= 1'b1;
        hold_p0   <= HOLD_W'(HOLD_TICKS);
      end else if (active_p0 && mux_clk) begin
        hold_p0 <= hold_p0 - 1'b1;
        if (hold_p0 == HOLD_W'(1)) active_p0 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (msg_req) msg_p0 <= msg_code;
  end

  logic blank_all;
`ifdef SCORE_DISP_FLASH_EN
  logic [6:0] flash_p0;

  always_ff @(posedge clk) begin
    if (rst) flash_p0 <= 7'd0;
    else if (msg_req) flash_p0 <= 7'd0;
    else if (active_p0 && mux_clk) flash_p0 <= flash_p0 + 7'd1;
  end

  assign blank_all = flash_p0[6];
`else
  assign blank_all = 1'b0;
`endif

  // output register stage
  logic [15:0] disp_nx;

  always_comb begin
    if (!active_p0) disp_nx = blank_lz(score_bcd_p1);
    else if (blank_all) disp_nx = 16'hFFFF;
    else disp_nx = msg_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {val1, val2, val3, val4} <= 16'hFFF0;
    end else begin
      {val1, val2, val3, val4} <= disp_nx;
    end
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
Sequencer/arbiter in front of the 4-digit 7-segment driver. It generates the driver's one-cycle digit-multiplex strobe and converts the binary game score to BCD with a sequential double-dabble. It also arbitrates the four digit values between the score and a timed message source (e.g. "2048" win banner, error codes). Its outputs connect directly to the driver's mux_clk and val1..val4 inputs.

Parameters:
- MUX_DIV, 100000: clk cycles per mux_clk strobe; legal range 2 or more.
- HOLD_TICKS, 500: number of mux_clk strobes a message stays displayed; legal range 1 or more.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- score, in, 14: binary score, sampled when score_valid is high.
- score_valid, in, 1: single-cycle load strobe for score.
- msg_req, in, 1: message request, level or pulse.
- msg_code, in, 16: message digits; [15:12] is val1 … [3:0] is val4. Values above 9 blank the digit.
- msg_ack, out, 1: one-cycle acknowledge; msg_code is latched on that cycle.
- busy, out, 1: BCD conversion in progress.
- mux_clk, out, 1: one-cycle strobe to the display driver.
- val1..val4, out, 4 each: digit values; val1 is the leftmost (thousands) digit. 4'hF means blank.

Behaviour:
- Reset values:
  - Prescaler count = 0, mux_clk = 0, msg_ack = 0, busy = 0.
  - Score BCD = 0000, message inactive, pending flag = 0.
  - Display shows blank, blank, blank, 0 (val1..val3 = F, val4 = 0).
- Prescaler:
  - Counts 0..MUX_DIV-1 and wraps to 0.
  - mux_clk = 1 exactly on the cycle the count equals MUX_DIV-1, so the period is MUX_DIV clk cycles.
  - Free-running; unaffected by any other activity.
- Conversion FSM (IDLE → CONV → LOAD → IDLE):
  - IDLE: score_valid = 1 latches min(score, 9999) into the shift register and enters CONV.
  - CONV: one shift/add-3 iteration per cycle, 14 cycles. busy = 1 throughout CONV and LOAD.
  - LOAD: one cycle; writes the 16-bit BCD result to the score register, then returns to IDLE.
  - Latency: val outputs reflect the new score 16 clk edges after the edge that sampled score_valid (when the score source is shown).
  - score_valid during CONV or LOAD: latched into a single-deep pending register; the latest value wins.
  - Pending score is serviced from IDLE on the cycle after LOAD, with the same 16-cycle latency.
- Arbiter:
  - Source is SCORE by default.
  - msg_req = 1 with no message active: msg_ack = 1 for one cycle, msg_code latched, hold counter = HOLD_TICKS, source switches to MSG the next cycle.
  - msg_req while a message is active: acked again, new code replaces the old one, hold counter reloads.
  - A level-held msg_req is re-acked every cycle; each ack reloads the hold counter.
  - Hold counter decrements on each mux_clk while MSG is active and not acked that cycle. When it reaches 0, source returns to SCORE on the next cycle.
  - Score conversions continue while MSG is shown; results become visible on return to SCORE.
- Leading-zero blanking (SCORE source only):
  - Leading zero digits in val1..val3 output F.
  - val4 is always shown, so score 0 displays as "   0".
  - MSG digits pass through unchanged.
- All outputs are registered. rst mid-conversion or mid-message aborts immediately to the reset values, and the pending score is discarded.

Optional Feature:
- Macro: SCORE_DISP_FLASH_EN.
- Defined: a 7-bit flash counter clears on each msg_ack and increments on each mux_clk while MSG is active. While flash counter bit 6 = 1, val1..val4 all output F, so the message blinks with a 128-strobe period.
- Undefined: no flash counter is built, and messages are steady.

Test Plan:
- Reset with MUX_DIV=4 → val = F,F,F,0; busy = 0; mux_clk pulses on cycles 3, 7, 11 after reset release (period 4).
- score=2048 with score_valid pulse → busy high for 15 cycles; 16 edges later val = 2,0,4,8.
- score=7 → F,F,F,7; score=305 → F,3,0,5; score=12000 → 9,9,9,9 (saturated).
- score_valid(100) then score_valid(64) 3 cycles later during CONV → 1,0,0 shown first, then F,F,6,4 16 cycles after the first LOAD completes.
- MUX_DIV=4, HOLD_TICKS=3, msg_req pulse with msg_code=16'hFE2F → one msg_ack, then val = F,E,2,F; reverts to the score after the 3rd mux_clk.
- Second msg_req during an active message → second ack, new code shown, full 3-tick hold restarts. Also assert rst mid-message → reset display next cycle.
